// File: rtl/symbol_interleaver.sv
// -----------------------------------------------------------------------------
// symbol_interleaver
//
// Bit interleaver/deinterleaver for OFDM symbols of 48, 96, 192 or 288 coded
// bits. Two ping-pong banks are used: the write side fills one bank while the
// read side drains the other. In interleave mode the permutation is applied
// on the write address and the bank is read sequentially. In deinterleave mode
// the bank is written sequentially and the permutation is applied on the read
// address.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : asynchronous, active-high reset
//   inputData    : coded bit in
//   inputValid   : inputData offered this cycle
//   inputReady   : bit accepted when inputValid && inputReady
//   mode         : 0=BPSK(48) 1=QPSK(96) 2=16QAM(192) 3=64QAM(288)
//   deint        : 0 = interleave, 1 = deinterleave
//   outputData   : permuted bit out
//   outputValid  : outputData is valid
//   outputReady  : bit consumed when outputValid && outputReady
//   symbolLast   : outputData is the last bit of the symbol
// -----------------------------------------------------------------------------
module symbol_interleaver #(
    parameter int MAX_NCBPS = 288,
    parameter int ADDR_W    = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inputData,
    input  logic       inputValid,
    output logic       inputReady,
    input  logic [1:0] mode,
    input  logic       deint,
    output logic       outputData,
    output logic       outputValid,
    input  logic       outputReady,
    output logic       symbolLast
);

    // Index of the last bit of a symbol for the given modulation.
    function automatic logic [ADDR_W-1:0] lastIndex(input logic [1:0] m);
        logic [ADDR_W-1:0] r;
        case (m)
            2'd0:    r = ADDR_W'(47);
            2'd1:    r = ADDR_W'(95);
            2'd2:    r = ADDR_W'(191);
            default: r = ADDR_W'(287);
        endcase
        return r;
    endfunction

    // Two-step permutation for one fixed (NCBPS, s) pair. NCBPS is always a
    // multiple of 16, so floor(16*i/NCBPS) reduces to floor(i/(NCBPS/16)).
    // Called only with constant n and s, so every division is by a constant.
    function automatic logic [ADDR_W-1:0] permFixed(input logic [ADDR_W-1:0] k,
                                                     input int n, input int s);
        int d;
        int i;
        int j;
        d = n / 16;
        i = d * int'(k[3:0]) + int'(k >> 4);
        j = s * (i / s) + ((i + n - (i / d)) % s);
        return ADDR_W'(j);
    endfunction

    function automatic logic [ADDR_W-1:0] permIndex(input logic [ADDR_W-1:0] k,
                                                     input logic [1:0] m);
        logic [ADDR_W-1:0] r;
        case (m)
            2'd0:    r = permFixed(k, 48, 1);
            2'd1:    r = permFixed(k, 96, 1);
            2'd2:    r = permFixed(k, 192, 2);
            default: r = permFixed(k, 288, 3);
        endcase
        return r;
    endfunction

    // Bank storage and per-bank symbol configuration
    logic              bankMem [2][MAX_NCBPS];
    logic [1:0]        bankMode [2];
    logic [1:0]        bankDeint;
    logic [1:0]        bankFull;
    logic [1:0]        fullNext;

    // Write side
    logic              wrBank;
    logic [ADDR_W-1:0] wrCnt;
    logic [1:0]        wrMode;
    logic              wrDeint;
    logic [ADDR_W-1:0] wrAddr;
    logic              wrLast;
    logic              wrFire;

    // Read side
    logic              rdBank;
    logic [ADDR_W-1:0] rdCnt;
    logic [1:0]        rdMode;
    logic              rdDeint;
    logic [ADDR_W-1:0] rdAddr;
    logic              rdLast;
    logic              rdAdvance;
    logic              rdFire;

    // ---- write stage: address generation into the bank being filled ----
    // The first bit of a symbol uses the live mode/deint; later bits use the
    // copy captured with that first bit, so mid-symbol changes are ignored.
    assign wrMode     = (wrCnt == '0) ? mode  : bankMode[wrBank];
    assign wrDeint    = (wrCnt == '0) ? deint : bankDeint[wrBank];
    assign wrAddr     = wrDeint ? wrCnt : permIndex(wrCnt, wrMode);
    assign wrLast     = (wrCnt == lastIndex(wrMode));

    // The write bank is only ever full when the read side still owns both.
    assign inputReady = !bankFull[wrBank];
    assign wrFire     = inputValid && inputReady;

    // ---- read stage: address generation out of the bank being drained ----
    assign rdMode    = bankMode[rdBank];
    assign rdDeint   = bankDeint[rdBank];
    assign rdAddr    = rdDeint ? permIndex(rdCnt, rdMode) : rdCnt;
    assign rdLast    = (rdCnt == lastIndex(rdMode));
    assign rdAdvance = !outputValid || outputReady;
    assign rdFire    = rdAdvance && bankFull[rdBank];

    // A write completing into one bank and a read completing on the other can
    // happen in the same cycle; they always touch different flags.
    always_comb begin
        fullNext = bankFull;
        if (rdFire && rdLast) begin
            fullNext[rdBank] = 1'b0;
        end
        if (wrFire && wrLast) begin
            fullNext[wrBank] = 1'b1;
        end
    end

    // Bank contents and stored configuration carry no reset.
    always_ff @(posedge clock) begin
        if (wrFire) begin
            bankMem[wrBank][wrAddr] <= inputData;
            if (wrCnt == '0) begin
                bankMode[wrBank]  <= mode;
                bankDeint[wrBank] <= deint;
            end
        end
    end

    // ---- control and output register ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrBank      <= 1'b0;
            wrCnt       <= '0;
            rdBank      <= 1'b0;
            rdCnt       <= '0;
            bankFull    <= '0;
            outputValid <= 1'b0;
            outputData  <= 1'b0;
            symbolLast  <= 1'b0;
        end else begin
            bankFull <= fullNext;

            if (wrFire) begin
                if (wrLast) begin
                    wrCnt  <= '0;
                    wrBank <= ~wrBank;
                end else begin
                    wrCnt <= wrCnt + ADDR_W'(1);
                end
            end

            // Output register reloads whenever it is empty or being consumed;
            // on the last bit of a bank the read side moves straight to the
            // other bank, so a waiting full bank streams without a bubble.
            if (rdFire) begin
                outputValid <= 1'b1;
                outputData  <= bankMem[rdBank][rdAddr];
                symbolLast  <= rdLast;
                if (rdLast) begin
                    rdCnt  <= '0;
                    rdBank <= ~rdBank;
                end else begin
                    rdCnt <= rdCnt + ADDR_W'(1);
                end
            end else if (rdAdvance) begin
                outputValid <= 1'b0;
                symbolLast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_symbol_interleaver.sv
module tb_symbol_interleaver;

    logic       clock;
    logic       reset;
    logic       inputData;
    logic       inputValid;
    logic       inputReady;
    logic [1:0] mode;
    logic       deint;
    logic       outputData;
    logic       outputValid;
    logic       outputReady;
    logic       symbolLast;

    symbol_interleaver #(.MAX_NCBPS(288), .ADDR_W(9)) dut (
        .clock       (clock),
        .reset       (reset),
        .inputData   (inputData),
        .inputValid  (inputValid),
        .inputReady  (inputReady),
        .mode        (mode),
        .deint       (deint),
        .outputData  (outputData),
        .outputValid (outputValid),
        .outputReady (outputReady),
        .symbolLast  (symbolLast)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: the permutation straight from its definition.
    function automatic int ncbpsOf(input int m);
        return (m == 0) ? 48 : (m == 1) ? 96 : (m == 2) ? 192 : 288;
    endfunction

    function automatic int jOf(input int k, input int m);
        int n;
        int s;
        int i;
        n = ncbpsOf(m);
        s = (m < 2) ? 1 : (m == 2) ? 2 : 3;
        i = (n / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + n - (16 * i) / n) % s;
    endfunction

    logic txBits [576];
    logic origBits [288];
    logic expBits [$];
    logic expLast [$];
    logic rxBits [$];
    logic rxLast [$];

    int rxCount = 0;
    int gapCount = 0;
    int gapTarget = 0;
    bit gapTrack = 1'b0;
    int firstValidCyc = -1;
    int stallCount = 0;
    int acceptCount = 0;
    int lastAcceptCyc = 0;
    int rdyMode = 1;
    bit sendDone = 1'b0;
    logic eb;
    logic el;

    // Output ready pattern: 0 = held low, 1 = held high, 2 = random backpressure
    always @(negedge clock) begin
        if (rdyMode == 2) outputReady = ($urandom_range(0, 3) != 0);
        else              outputReady = (rdyMode == 1);
    end

    // Output monitor and scoreboard, sampled mid-cycle
    always begin
        @(negedge clock);
        #1;
        if (!reset) begin
            if (outputValid && firstValidCyc < 0) firstValidCyc = cyc;
            if (gapTrack && rxCount > 0 && rxCount < gapTarget && !outputValid) gapCount++;
            if (outputValid && outputReady) begin
                rxBits.push_back(outputData);
                rxLast.push_back(symbolLast);
                rxCount++;
                if (expBits.size() == 0) begin
                    checkEq("unexpected_output", 32'(1), 32'(0));
                end else begin
                    eb = expBits.pop_front();
                    el = expLast.pop_front();
                    checkEq("outData", 32'(outputData), 32'(eb));
                    checkEq("symLast", 32'(symbolLast), 32'(el));
                end
            end
        end
    end

    task automatic pushExpected(input int m, input logic d, input int off);
        int n;
        logic outv [288];
        n = ncbpsOf(m);
        for (int k = 0; k < n; k++) begin
            if (d) outv[k] = txBits[off + jOf(k, m)];
            else   outv[jOf(k, m)] = txBits[off + k];
        end
        for (int p = 0; p < n; p++) begin
            expBits.push_back(outv[p]);
            expLast.push_back(p == n - 1);
        end
    endtask

    // Called and returns at a falling edge.
    task automatic sendBit(input logic b, input logic [1:0] m, input logic d, input int gapPct);
        int w;
        while (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
            inputValid = 1'b0;
            mode = 2'($urandom_range(0, 3));
            @(negedge clock);
        end
        inputValid = 1'b1;
        inputData = b;
        mode = m;
        deint = d;
        w = 0;
        while (!inputReady && w < 3000) begin
            @(negedge clock);
            w++;
            stallCount++;
        end
        if (w >= 3000) checkEq("inputReady_timeout", 32'(inputReady), 32'(1));
        @(negedge clock);
        inputValid = 1'b0;
        lastAcceptCyc = cyc;
        acceptCount++;
    endtask

    // Mode/deint are scrambled on every bit after the first of a symbol.
    task automatic sendSymbol(input int m, input logic d, input int gapPct, input int off);
        int n;
        n = ncbpsOf(m);
        pushExpected(m, d, off);
        for (int k = 0; k < n; k++) begin
            if (k == 0) sendBit(txBits[off], 2'(m), d, gapPct);
            else sendBit(txBits[off + k], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), gapPct);
        end
    endtask

    task automatic waitDrain(input int budget);
        int w;
        w = 0;
        while (expBits.size() > 0 && w < budget) begin
            @(negedge clock);
            w++;
        end
        checkEq("drain_left", 32'(expBits.size()), 32'(0));
        @(negedge clock);
    endtask

    task automatic clearRx();
        rxBits.delete();
        rxLast.delete();
        rxCount = 0;
    endtask

    function automatic int onesIn();
        int c;
        c = 0;
        foreach (rxBits[p]) if (rxBits[p]) c++;
        return c;
    endfunction

    task automatic loadSingle(input int n, input int pos);
        for (int k = 0; k < n; k++) txBits[k] = (k == pos);
    endtask

    task automatic loadRandom(input int n);
        for (int k = 0; k < n; k++) txBits[k] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got 0, expected 1");
        testsFailed++;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc287;
        int accBase;
        int w;
        int mism;
        logic d0;

        reset = 1'b1;
        inputValid = 1'b0;
        inputData = 1'b0;
        mode = 2'd0;
        deint = 1'b0;
        repeat (3) @(negedge clock);
        checkEq("rst_outputValid", 32'(outputValid), 32'(0));
        checkEq("rst_outputData", 32'(outputData), 32'(0));
        checkEq("rst_symbolLast", 32'(symbolLast), 32'(0));
        checkEq("rst_inputReady", 32'(inputReady), 32'(1));
        reset = 1'b0;
        checkEq("post_rst_ready", 32'(inputReady), 32'(1));

        // BPSK single-one impulses
        loadSingle(48, 1);
        clearRx();
        sendSymbol(0, 1'b0, 0, 0);
        waitDrain(500);
        checkEq("bpsk_k1_pos3", 32'(rxBits[3]), 32'(1));
        checkEq("bpsk_k1_ones", 32'(onesIn()), 32'(1));
        loadSingle(48, 16);
        clearRx();
        sendSymbol(0, 1'b0, 0, 0);
        waitDrain(500);
        checkEq("bpsk_k16_pos1", 32'(rxBits[1]), 32'(1));
        checkEq("bpsk_k16_ones", 32'(onesIn()), 32'(1));

        // 64QAM impulse
        loadSingle(288, 1);
        clearRx();
        sendSymbol(3, 1'b0, 0, 0);
        waitDrain(1000);
        checkEq("qam64_k1_pos20", 32'(rxBits[20]), 32'(1));
        checkEq("qam64_k1_ones", 32'(onesIn()), 32'(1));
        checkEq("qam64_last287", 32'(rxLast[287]), 32'(1));
        checkEq("qam64_rxcount", 32'(rxCount), 32'(288));

        // 64QAM back-to-back streaming
        loadRandom(576);
        clearRx();
        stallCount = 0;
        firstValidCyc = -1;
        gapCount = 0;
        gapTarget = 576;
        gapTrack = 1'b1;
        sendSymbol(3, 1'b0, 0, 0);
        acc287 = lastAcceptCyc;
        sendSymbol(3, 1'b0, 0, 288);
        waitDrain(2000);
        gapTrack = 1'b0;
        checkEq("stream_stalls", 32'(stallCount), 32'(0));
        checkEq("stream_first_latency", 32'(firstValidCyc - acc287), 32'(1));
        checkEq("stream_gaps", 32'(gapCount), 32'(0));
        checkEq("stream_rxcount", 32'(rxCount), 32'(576));

        // Interleave then deinterleave round trip, every mode, with gaps and backpressure
        rdyMode = 2;
        for (int m = 0; m < 4; m++) begin
            loadRandom(ncbpsOf(m));
            for (int k = 0; k < ncbpsOf(m); k++) origBits[k] = txBits[k];
            clearRx();
            sendSymbol(m, 1'b0, 20, 0);
            waitDrain(5000);
            for (int k = 0; k < ncbpsOf(m); k++) txBits[k] = rxBits[k];
            clearRx();
            sendSymbol(m, 1'b1, 20, 0);
            waitDrain(5000);
            mism = 0;
            for (int k = 0; k < ncbpsOf(m); k++) if (rxBits.size() <= k || rxBits[k] !== origBits[k]) mism++;
            checkEq($sformatf("roundtrip_mode%0d", m), 32'(mism), 32'(0));
        end

        // 16QAM with output blocked across three offered symbols
        rdyMode = 0;
        repeat (2) @(negedge clock);
        loadRandom(576);
        clearRx();
        accBase = acceptCount;
        sendDone = 1'b0;
        fork
            begin
                sendSymbol(2, 1'b0, 0, 0);
                sendSymbol(2, 1'b0, 0, 192);
                sendSymbol(2, 1'b0, 0, 384);
                sendDone = 1'b1;
            end
        join_none
        repeat (500) @(negedge clock);
        checkEq("blocked_accepted", 32'(acceptCount - accBase), 32'(384));
        checkEq("blocked_inputReady", 32'(inputReady), 32'(0));
        checkEq("blocked_outputValid", 32'(outputValid), 32'(1));
        checkEq("blocked_firstbit", 32'(outputData), 32'(expBits[0]));
        d0 = outputData;
        repeat (20) @(negedge clock);
        checkEq("frozen_data", 32'(outputData), 32'(d0));
        checkEq("frozen_valid", 32'(outputValid), 32'(1));
        checkEq("frozen_last", 32'(symbolLast), 32'(0));
        rdyMode = 1;
        w = 0;
        while (!sendDone && w < 3000) begin
            @(negedge clock);
            w++;
        end
        checkEq("blocked_senddone", 32'(sendDone), 32'(1));
        waitDrain(2000);
        checkEq("blocked_rxcount", 32'(rxCount), 32'(576));

        // Reset mid-operation: one full QPSK symbol streaming, 4 bits into the next
        loadRandom(96);
        clearRx();
        sendSymbol(1, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++) sendBit(1'($urandom_range(0, 1)), 2'd1, 1'b0, 0);
        checkEq("prerst_outputValid", 32'(outputValid), 32'(1));
        reset = 1'b1;
        #1;
        checkEq("midrst_outputValid", 32'(outputValid), 32'(0));
        checkEq("midrst_outputData", 32'(outputData), 32'(0));
        checkEq("midrst_symbolLast", 32'(symbolLast), 32'(0));
        checkEq("midrst_inputReady", 32'(inputReady), 32'(1));
        expBits.delete();
        expLast.delete();
        @(negedge clock);
        reset = 1'b0;
        clearRx();
        checkEq("afterrst_inputReady", 32'(inputReady), 32'(1));
        loadRandom(96);
        sendSymbol(1, 1'b0, 0, 0);
        waitDrain(1000);
        checkEq("afterrst_rxcount", 32'(rxCount), 32'(96));

        repeat (5) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/symbol_interleaver.md
SYMBOL_INTERLEAVER -- requirements
Module: symbol_interleaver

Interface
REQ-001 SHALL have parameter MAX_NCBPS, default 288, meaning the largest symbol size in coded bits and the depth of each bank.
REQ-002 SHALL have parameter ADDR_W, default 9, meaning the bank address width; ceil(log2(MAX_NCBPS)) <= ADDR_W.
REQ-003 SHALL have port clock  input  1  as the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  as the asynchronous, active-high reset.
REQ-005 SHALL have port inputData  input  1  as the coded bit in.
REQ-006 SHALL have port inputValid  input  1  meaning inputData is offered this cycle.
REQ-007 SHALL have port inputReady  output  1  meaning the bit is accepted when inputValid && inputReady.
REQ-008 SHALL have port mode  input  2  with 0=BPSK (NCBPS 48, s=1), 1=QPSK (96, s=1), 2=16QAM (192, s=2), 3=64QAM (288, s=3).
REQ-009 SHALL have port deint  input  1  with 0 = interleave and 1 = deinterleave.
REQ-010 SHALL have port outputData  output  1  as the permuted bit out.
REQ-011 SHALL have port outputValid  output  1  meaning outputData is valid.
REQ-012 SHALL have port outputReady  input  1  meaning the bit is consumed when outputValid && outputReady.
REQ-013 SHALL have port symbolLast  output  1  meaning outputData is the last bit of a symbol; qualified by outputValid.

Function
REQ-014 SHALL compute j(k) for input index k as follows:
- i = (NCBPS/16)*(k mod 16) + floor(k/16).
- j = s*floor(i/s) + (i + NCBPS - floor(16*i/NCBPS)) mod s.
REQ-015 SHALL, in interleave mode, write accepted bit k to bank address j(k) and read addresses 0..NCBPS-1 sequentially, so that out[j(k)] = in[k].
REQ-016 SHALL, in deinterleave mode, write sequentially and read address j(k) for k = 0..NCBPS-1, so that out[k] = in[j(k)].
REQ-017 SHALL use two banks (ping-pong), each MAX_NCBPS x 1 bit; the write side fills one bank while the read side drains the other.
REQ-018 SHALL sample mode and deint on the first accepted bit of each symbol (write count 0) and store them with the bank; changes mid-symbol SHALL be ignored until the next symbol.
REQ-019 SHALL mark a bank full and hand it to the read side on acceptance of bit NCBPS-1; the write counter then wraps to 0 and the write side moves to the other bank.
REQ-020 SHALL drive inputReady low only when both banks are full; it SHALL return high the cycle after the last read of a bank completes.
REQ-021 SHALL assert outputValid with the first output bit exactly one cycle after the clock edge that accepts the last input bit of a symbol, when the read side is idle.
REQ-022 SHALL hold outputData, outputValid and symbolLast stable while outputValid && !outputReady.
REQ-023 SHALL, when the next bank is already full at the last read of the current bank, stream its first bit on the next cycle with no bubble.
REQ-024 SHALL let both operations proceed when the last write into one bank and the last read of the other occur in the same cycle; inputReady SHALL stay high.
REQ-025 SHALL assert symbolLast with read index NCBPS-1.
REQ-026 SHALL, when inputValid is low, pause the write counter with no effect on the read side.

Reset
REQ-027 SHALL, on reset assertion and regardless of clock:
- force outputValid=0, outputData=0, symbolLast=0 and inputReady=1;
- clear both counters, both full flags and the bank select.
REQ-028 SHALL discard any partial or full symbol when reset is asserted mid-operation; bank contents need not be cleared.
REQ-029 SHALL accept input on the first rising edge after reset deasserts.

Verification
REQ-030 SHALL pass this case: mode=0, deint=0, single '1' at k=1 in 48 bits -> single '1' at output position 3; '1' at k=16 -> position 1.
REQ-031 SHALL pass this case: mode=3, deint=0, single '1' at k=1 in 288 bits -> single '1' at output position 20; symbolLast at position 287.
REQ-032 SHALL pass this case: mode=3, 576 random bits back-to-back, outputReady=1 -> 576 output bits with no gap after the first and inputReady always 1; first outputValid 1 cycle after bit 287 is accepted.
REQ-033 SHALL pass this case: any mode, interleave output fed to a second instance with deint=1 -> the second instance's output equals the original input bit-for-bit, for all four modes.
REQ-034 SHALL pass this case: mode=2, outputReady=0 while 3 symbols are offered -> inputReady falls after bit 383 and outputData stays frozen; outputReady=1 -> all 576 buffered bits are delivered correctly.
REQ-035 SHALL pass this case: reset pulsed at input bit 100 of a mode=1 symbol -> outputs return to reset values; a fresh 96-bit symbol then gives correct output with no residue.
